// File: rtl/delay_line_prog.sv
// delay_line_prog: programmable-depth delay line for data plus a valid qualifier.
// The delay is selected at runtime (1..MAX_DEPTH clock-enabled cycles). Changing the
// selected depth, flush and reset all empty the pipe. Output is a combinational tap
// of the registered stage selected by depth_cur.
//
// Handshake: d_valid qualifies d on every edge where ce=1 and no flush/depth change
// occurs; there is no ready signal because the pipe accepts one word per ce cycle
// unconditionally. q_valid qualifies q; the consumer must take q whenever q_valid=1,
// because the next ce edge replaces it.
module delay_line_prog #(
  parameter int WIDTH      = 8,
  parameter int MAX_DEPTH  = 8,
  parameter int SEL_W      = 4,
  parameter int RST_DEPTH  = 3,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic [SEL_W-1:0] depth_sel,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [SEL_W-1:0] depth_cur,
  output logic             busy
);

  // Stage 1 is nearest the input; stage[depth_cur] is the output tap.
  logic [WIDTH-1:0] data_r [1:MAX_DEPTH];
  logic [MAX_DEPTH:1] valid_r;
  logic [SEL_W-1:0]   depth_r;
  logic [SEL_W-1:0]   sel_c;
  logic               depth_change;
  logic               clear_pipe;
  logic               do_shift;

  // Clamp the requested depth into the legal range 1..MAX_DEPTH.
  always_comb begin
    sel_c = depth_sel;
    if (depth_sel == '0) begin
      sel_c = SEL_W'(1);
    end else if (depth_sel > SEL_W'(MAX_DEPTH)) begin
      sel_c = SEL_W'(MAX_DEPTH);
    end
  end

  // Edge qualifiers. A depth change acts regardless of ce and empties the pipe
  // so that no word ever leaves with a latency other than the one it entered under.
  always_comb begin
    depth_change = (sel_c != depth_r);
    clear_pipe   = depth_change || flush;
    do_shift     = ce && !clear_pipe;
  end

  // Depth register: reset value, then follows the clamped selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_r <= SEL_W'(RST_DEPTH);
    end else if (depth_change) begin
      depth_r <= sel_c;
    end
  end

  // Valid bits: cleared by reset/flush/depth change, otherwise shift on ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (clear_pipe) begin
      valid_r <= '0;
    end else if (do_shift) begin
      valid_r <= {valid_r[MAX_DEPTH-1:1], d_valid};
    end
  end

  // Data stages: optionally zeroed on reset/flush/depth change, otherwise shift
  // on ce. Bubble data shifts too, so q shows whatever was presented with d_valid=0.
  always_ff @(posedge clk) begin
    if (rst || clear_pipe) begin
      if (CLEAR_DATA) begin
        for (int i = 1; i <= MAX_DEPTH; i++) begin
          data_r[i] <= '0;
        end
      end
    end else if (do_shift) begin
      data_r[1] <= d;
      for (int i = 2; i <= MAX_DEPTH; i++) begin
        data_r[i] <= data_r[i-1];
      end
    end
  end

  // Output tap and occupancy: select stage[depth_cur]; busy looks only at the
  // stages inside the active depth, the deeper stages are ignored.
  always_comb begin
    q       = '0;
    q_valid = 1'b0;
    busy    = 1'b0;
    for (int i = 1; i <= MAX_DEPTH; i++) begin
      if (SEL_W'(i) == depth_r) begin
        q       = data_r[i];
        q_valid = valid_r[i];
      end
      if (SEL_W'(i) <= depth_r) begin
        busy = busy | valid_r[i];
      end
    end
  end

  assign depth_cur = depth_r;

endmodule

// File: tb/tb_delay_line_prog.sv
// tb_delay_line_prog: directed and random stimulus for delay_line_prog with a
// queue-based scoreboard; a monitor process checks every edge's outcome.
module tb_delay_line_prog;

  localparam int WIDTH     = 8;
  localparam int MAX_DEPTH = 8;
  localparam int SEL_W     = 4;
  localparam int RST_DEPTH = 3;

  logic             clk;
  logic             rst;
  logic             ce;
  logic             flush;
  logic [SEL_W-1:0] depth_sel;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [SEL_W-1:0] depth_cur;
  logic             busy;

  delay_line_prog #(
    .WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH), .SEL_W(SEL_W),
    .RST_DEPTH(RST_DEPTH), .CLEAR_DATA(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .depth_sel(depth_sel),
    .d(d), .d_valid(d_valid), .q(q), .q_valid(q_valid),
    .depth_cur(depth_cur), .busy(busy)
  );

  // Clock / reset block: reset is driven through the driver task.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum logic [2:0] {K_NONE, K_RST, K_CHG, K_FLUSH, K_SHIFT, K_HOLD} kind_t;

  kind_t            last_kind = K_NONE;
  int unsigned      shift_n   = 0;
  int               m_depth   = RST_DEPTH;
  logic [WIDTH-1:0] exp_q[$];
  int unsigned      due_q[$];
  int               checks    = 0;
  int               failures  = 0;
  logic [SEL_W-1:0] cur_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input logic [SEL_W-1:0] s);
    if (s == 0) return 1;
    if (int'(s) > MAX_DEPTH) return MAX_DEPTH;
    return int'(s);
  endfunction

  // Driver: apply one edge's inputs, then record what that edge must do.
  task automatic cyc(input logic r, input logic c, input logic f,
                     input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] dd,
                     input logic dv);
    int sc;
    rst = r; ce = c; flush = f; depth_sel = s; d = dd; d_valid = dv;
    sc = clamp(s);
    @(posedge clk);
    if (r) begin
      last_kind = K_RST; m_depth = RST_DEPTH;
      exp_q.delete(); due_q.delete();
    end else if (sc != m_depth) begin
      last_kind = K_CHG; m_depth = sc;
      exp_q.delete(); due_q.delete();
    end else if (f) begin
      last_kind = K_FLUSH;
      exp_q.delete(); due_q.delete();
    end else if (c) begin
      last_kind = K_SHIFT;
      shift_n++;
      if (dv) begin
        exp_q.push_back(dd);
        due_q.push_back(shift_n + unsigned'(m_depth) - 1);
      end
    end else begin
      last_kind = K_HOLD;
    end
    #2;
  endtask

  task automatic run(input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] dd, input logic dv);
    cyc(1'b0, 1'b1, 1'b0, s, dd, dv);
  endtask

  task automatic hold(input logic [SEL_W-1:0] s);
    cyc(1'b0, 1'b0, 1'b0, s, 8'hEE, 1'b1);
  endtask

  // Monitor / scoreboard: pops the expected word when its due shift arrives.
  initial begin
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] e;
    logic             m_qv;
    logic             present;
    prev_q = '0;
    m_qv   = 1'b0;
    forever begin
      @(negedge clk);
      case (last_kind)
        K_RST, K_CHG, K_FLUSH: begin
          m_qv = 1'b0;
          chk("clr_q_valid", q_valid, 0);
          chk("clr_q", q, 0);
        end
        K_SHIFT: begin
          present = (due_q.size() != 0) && (due_q[0] == shift_n);
          m_qv = present;
          chk("q_valid", q_valid, present);
          if (present) begin
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            chk("q_data", q, e);
          end
        end
        K_HOLD: begin
          chk("hold_q_valid", q_valid, m_qv);
          chk("hold_q", q, prev_q);
        end
        default: ;
      endcase
      if (last_kind != K_NONE) begin
        chk("busy", busy, m_qv || (exp_q.size() != 0));
        chk("depth_cur", depth_cur, m_depth);
      end
      prev_q = q;
    end
  end

  // Directed vectors with hand-computed values, then a random phase.
  initial begin
    // Reset
    cyc(1'b1, 1'b0, 1'b0, 4'd3, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'd3, 8'h99, 1'b1);
    chk("rst_q", q, 0); chk("rst_q_valid", q_valid, 0);
    chk("rst_busy", busy, 0); chk("rst_depth", depth_cur, 3);

    // 1: depth 3, three words back to back
    run(4'd3, 8'h11, 1'b1);
    run(4'd3, 8'h22, 1'b1);
    chk("t1_not_yet", q_valid, 0);
    run(4'd3, 8'h33, 1'b1);
    chk("t1_w0", q, 8'h11); chk("t1_w0_v", q_valid, 1);
    run(4'd3, 8'h00, 1'b0); chk("t1_w1", q, 8'h22);
    run(4'd3, 8'h00, 1'b0); chk("t1_w2", q, 8'h33);
    run(4'd3, 8'h00, 1'b0); chk("t1_drain_v", q_valid, 0); chk("t1_drain_busy", busy, 0);

    // 2: depth 4 with ce toggling
    run(4'd4, 8'h00, 1'b0);
    chk("t2_depth", depth_cur, 4);
    run(4'd4, 8'hA0, 1'b1); hold(4'd4);
    run(4'd4, 8'hA1, 1'b1); hold(4'd4);
    run(4'd4, 8'hA2, 1'b1); hold(4'd4);
    run(4'd4, 8'hA3, 1'b1);
    chk("t2_a0", q, 8'hA0); chk("t2_a0_v", q_valid, 1);
    hold(4'd4);
    chk("t2_freeze", q, 8'hA0); chk("t2_freeze_v", q_valid, 1);
    run(4'd4, 8'h00, 1'b0); chk("t2_a1", q, 8'hA1);
    hold(4'd4); run(4'd4, 8'h00, 1'b0); chk("t2_a2", q, 8'hA2);
    hold(4'd4); run(4'd4, 8'h00, 1'b0); chk("t2_a3", q, 8'hA3);
    run(4'd4, 8'h00, 1'b0); chk("t2_end_v", q_valid, 0);

    // 3: depth change 3 -> 5 mid-stream
    run(4'd3, 8'hB9, 1'b1);
    chk("t3_depth3", depth_cur, 3);
    run(4'd3, 8'hB0, 1'b1); run(4'd3, 8'hB1, 1'b1); run(4'd3, 8'hB2, 1'b1);
    chk("t3_b0", q, 8'hB0);
    run(4'd3, 8'hB3, 1'b1);
    run(4'd5, 8'hB4, 1'b1);
    chk("t3_depth5", depth_cur, 5); chk("t3_chg_v", q_valid, 0); chk("t3_chg_busy", busy, 0);
    run(4'd5, 8'hC0, 1'b1);
    for (int i = 0; i < 3; i++) run(4'd5, 8'h00, 1'b0);
    chk("t3_early", q_valid, 0);
    run(4'd5, 8'h00, 1'b0);
    chk("t3_c0", q, 8'hC0); chk("t3_c0_v", q_valid, 1);

    // 4: clamp boundaries
    run(4'd0, 8'hFF, 1'b1);
    chk("t4_depth1", depth_cur, 1); chk("t4_chg_v", q_valid, 0);
    run(4'd0, 8'h77, 1'b1);
    chk("t4_d1", q, 8'h77); chk("t4_d1_v", q_valid, 1);
    run(4'd0, 8'h00, 1'b0); chk("t4_d1_end", q_valid, 0);
    run(4'd15, 8'h00, 1'b0);
    chk("t4_depth8", depth_cur, 8);
    run(4'd15, 8'h5A, 1'b1);
    for (int i = 0; i < 6; i++) run(4'd15, 8'h00, 1'b0);
    chk("t4_d8_early", q_valid, 0);
    run(4'd15, 8'h00, 1'b0);
    chk("t4_5a", q, 8'h5A); chk("t4_5a_v", q_valid, 1);
    run(4'd8, 8'h66, 1'b1);
    chk("t4_same_clamp", depth_cur, 8); chk("t4_same_busy", busy, 1);
    for (int i = 0; i < 7; i++) run(4'd8, 8'h00, 1'b0);
    chk("t4_66", q, 8'h66);

    // 5: flush with three words in flight
    run(4'd4, 8'h00, 1'b0);
    run(4'd4, 8'hD0, 1'b1); run(4'd4, 8'hD1, 1'b1); run(4'd4, 8'hD2, 1'b1);
    chk("t5_busy_pre", busy, 1);
    cyc(1'b0, 1'b1, 1'b1, 4'd4, 8'hDD, 1'b1);
    chk("t5_flush_v", q_valid, 0); chk("t5_flush_busy", busy, 0); chk("t5_flush_q", q, 0);
    run(4'd4, 8'hE0, 1'b1);
    for (int i = 0; i < 3; i++) run(4'd4, 8'h00, 1'b0);
    chk("t5_e0", q, 8'hE0); chk("t5_e0_v", q_valid, 1);
    cyc(1'b0, 1'b0, 1'b1, 4'd4, 8'h00, 1'b0);
    chk("t5_flush_noce_v", q_valid, 0); chk("t5_flush_noce_busy", busy, 0);

    // 6: reset mid-stream with depth_sel=6
    run(4'd6, 8'h00, 1'b0);
    run(4'd6, 8'hF0, 1'b1); run(4'd6, 8'hF1, 1'b1); run(4'd6, 8'hF2, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 4'd6, 8'hF3, 1'b1);
      chk("t6_rst_depth", depth_cur, RST_DEPTH); chk("t6_rst_v", q_valid, 0); chk("t6_rst_q", q, 0);
    end
    run(4'd6, 8'hF4, 1'b1);
    chk("t6_depth6", depth_cur, 6); chk("t6_post_v", q_valid, 0); chk("t6_post_q", q, 0);

    // Random phase against the scoreboard
    cur_sel = 4'd6;
    for (int i = 0; i < 400; i++) begin
      logic r, f, c, dv;
      logic [WIDTH-1:0] dd;
      r  = ($urandom_range(0, 99) == 0);
      f  = ($urandom_range(0, 99) < 3);
      c  = ($urandom_range(0, 99) < 70);
      dv = 1'($urandom_range(0, 1));
      dd = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 3) cur_sel = 4'($urandom_range(0, 15));
      cyc(r, c, f, cur_sel, dd, dv);
    end
    for (int i = 0; i < 10; i++) run(cur_sel, 8'h00, 1'b0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
